// File: rtl/axi4_slave_mem_if.sv
// Five-channel AXI4 bundle between a master and the axi4_slave_mem target.
// Clock and reset stay outside so the bundle carries only channel traffic.
interface axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a word array; FIXED/INCR/WRAP bursts of 4-byte beats.
// Write and read paths are independent FSMs that run concurrently.
module axi4_slave_mem #(
  parameter int MEM_DEPTH  = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  axi4_slave_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  logic [31:0] mem [MEM_DEPTH];

  // WRAP boundaries are power-of-two sized, so the wrap reduces to a mask of {len, 2'b11}.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] result;
    mask = ADDR_WIDTH'({len, 2'b11});
    case (burst)
      2'b01:   result = addr + ADDR_WIDTH'(4);
      2'b10:   result = (addr & ~mask) | ((addr + ADDR_WIDTH'(4)) & mask);
      default: result = addr;
    endcase
    return result;
  endfunction

  function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [1:0]            w_burst;
  logic                  w_cfg_err;
  logic                  b_err;
  logic [ADDR_WIDTH-3:0] w_idx;
  logic                  w_range_err;
  logic                  w_last;
  logic                  w_mem_en;

  assign w_idx       = w_addr[ADDR_WIDTH-1:2];
  assign w_range_err = (w_idx >= DEPTH_WORDS);
  assign w_last      = (w_cnt == w_len);
  assign w_mem_en    = (w_state == W_DATA) && bus.WVALID && !w_cfg_err && !w_range_err;

  assign bus.AWREADY = (w_state == W_IDLE);
  assign bus.WREADY  = (w_state == W_DATA);
  assign bus.BVALID  = (w_state == W_RESP);
  assign bus.BRESP   = {b_err, 1'b0};

  // The beat counter, not WLAST, ends the burst; a WLAST disagreement only taints BRESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state   <= W_IDLE;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= '0;
      w_cfg_err <= 1'b0;
      b_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (bus.AWVALID) begin
          w_addr    <= bus.AWADDR;
          w_len     <= bus.AWLEN;
          w_burst   <= bus.AWBURST;
          w_cnt     <= '0;
          w_cfg_err <= cfg_bad(bus.AWSIZE, bus.AWBURST, bus.AWLEN);
          b_err     <= 1'b0;
          w_state   <= W_DATA;
        end
        W_DATA: if (bus.WVALID) begin
          b_err  <= b_err | w_cfg_err | w_range_err | (bus.WLAST != w_last);
          w_addr <= next_addr(w_addr, w_len, w_burst);
          w_cnt  <= w_cnt + 8'd1;
          if (w_last) w_state <= W_RESP;
        end
        W_RESP: if (bus.BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.WSTRB[b]) mem[w_idx[IDX_W-1:0]][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_burst;
  logic                  r_cfg_err;
  logic                  r_valid;
  logic [31:0]           r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-3:0] rd_idx;
  logic                  rd_err;
  logic [31:0]           rd_data;

  // The beat about to be presented comes from the AR channel when idle, else from the burst state.
  always_comb begin
    rd_addr = r_addr;
    rd_err  = r_cfg_err;
    if (r_state == R_IDLE) begin
      rd_addr = bus.ARADDR;
      rd_err  = cfg_bad(bus.ARSIZE, bus.ARBURST, bus.ARLEN);
    end
    rd_idx  = rd_addr[ADDR_WIDTH-1:2];
    rd_err  = rd_err || (rd_idx >= DEPTH_WORDS);
    rd_data = rd_err ? 32'd0 : mem[rd_idx[IDX_W-1:0]];
  end

  assign bus.ARREADY = (r_state == R_IDLE);
  assign bus.RVALID  = r_valid;
  assign bus.RDATA   = r_data;
  assign bus.RRESP   = r_resp;
  assign bus.RLAST   = r_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_cfg_err <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_resp    <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (bus.ARVALID) begin
          r_len     <= bus.ARLEN;
          r_burst   <= bus.ARBURST;
          r_cfg_err <= cfg_bad(bus.ARSIZE, bus.ARBURST, bus.ARLEN);
          r_addr    <= next_addr(bus.ARADDR, bus.ARLEN, bus.ARBURST);
          r_cnt     <= '0;
          r_valid   <= 1'b1;
          r_data    <= rd_data;
          r_resp    <= {rd_err, 1'b0};
          r_last    <= (bus.ARLEN == 8'd0);
          r_state   <= R_DATA;
        end
        R_DATA: if (bus.RREADY) begin
          if (r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= R_IDLE;
          end else begin
            r_data <= rd_data;
            r_resp <= {rd_err, 1'b0};
            r_last <= ((r_cnt + 8'd1) == r_len);
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= next_addr(r_addr, r_len, r_burst);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Scoreboard bench for axi4_slave_mem: expected B and R responses are queued
// from a reference memory model when stimulus is driven, and popped as the DUT answers.
module tb_axi4_slave_mem;
  logic clk = 1'b0;
  logic reset;

  axi4_slave_mem_if bus ();

  axi4_slave_mem #(.MEM_DEPTH(64), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [64];
  logic [1:0]  bq [$];
  rbeat_t      rq [$];
  logic        holdValid = 1'b0;
  logic [31:0] holdData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference address sequence written straight from the boundary/modulo definition.
  function automatic logic [31:0] nextAddr(input logic [31:0] a, input int len, input logic [1:0] burst);
    logic [31:0] wb, bnd;
    case (burst)
      2'b00: return a;
      2'b01: return a + 32'd4;
      2'b10: begin
        wb  = 32'((len + 1) * 4);
        bnd = a - (a % wb);
        return bnd + ((a + 32'd4 - bnd) % wb);
      end
      default: return a;
    endcase
  endfunction

  function automatic logic cfgErr(input logic [2:0] size, input logic [1:0] burst, input int len);
    return (size != 3'b010) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic expectWrite(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                             input int earlyLast);
    logic [31:0] a;
    logic        err, beatErr, wl;
    int          idx, lastAt;
    a      = addr;
    err    = 1'b0;
    lastAt = (earlyLast >= 0) ? earlyLast : len;
    for (int i = 0; i <= len; i++) begin
      idx     = int'(a >> 2);
      wl      = (i == lastAt);
      beatErr = cfgErr(size, burst, len) || (idx >= 64);
      if (!beatErr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[idx][8*b +: 8] = 8'((base + 32'(i)) >> (8*b));
      end
      err = err || beatErr || (wl != (i == len));
      a   = nextAddr(a, len, burst);
    end
    bq.push_back(err ? 2'b10 : 2'b00);
  endtask

  task automatic expectRead(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst);
    logic [31:0] a;
    rbeat_t      e;
    int          idx;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      idx    = int'(a >> 2);
      e.resp = (cfgErr(size, burst, len) || idx >= 64) ? 2'b10 : 2'b00;
      e.data = (e.resp == 2'b00) ? model[idx] : 32'd0;
      e.last = (i == len);
      rq.push_back(e);
      a = nextAddr(a, len, burst);
    end
  endtask

  task automatic sendAw(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.AWADDR = addr; bus.AWLEN = 8'(len); bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    @(negedge clk);
    while (!bus.AWREADY && n < 50) begin @(negedge clk); n++; end
    checkOutput("aw_handshake", 32'(bus.AWREADY), 32'd1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic sendAr(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.ARADDR = addr; bus.ARLEN = 8'(len); bus.ARSIZE = size; bus.ARBURST = burst; bus.ARVALID = 1'b1;
    @(negedge clk);
    while (!bus.ARREADY && n < 50) begin @(negedge clk); n++; end
    checkOutput("ar_handshake", 32'(bus.ARREADY), 32'd1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    @(negedge clk);
    while (!bus.WREADY && n < 50) begin @(negedge clk); n++; end
    checkOutput("w_handshake", 32'(bus.WREADY), 32'd1);
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    bus.BREADY = 1'b1;
    bus.RREADY = 1'b1;
    while ((bq.size() + rq.size()) > 0 && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("drain", 32'(bq.size() + rq.size()), 32'd0);
  endtask

  task automatic doWrite(input logic [31:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                         input int earlyLast, input bit holdB);
    int lastAt;
    lastAt = (earlyLast >= 0) ? earlyLast : len;
    expectWrite(addr, len, size, burst, base, strb, earlyLast);
    bus.BREADY = !holdB;
    sendAw(addr, len, size, burst);
    for (int i = 0; i <= len; i++) sendW(base + 32'(i), strb, i == lastAt);
    checkOutput("bvalid_after_last", 32'(bus.BVALID), 32'd1);
    if (holdB) begin
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("bvalid_held", 32'(bus.BVALID), 32'd1);
      checkOutput("awready_during_b", 32'(bus.AWREADY), 32'd0);
    end
    waitDrain();
    checkOutput("awready_after_b", 32'(bus.AWREADY), 32'd1);
  endtask

  task automatic doRead(input logic [31:0] addr, input int len, input logic [2:0] size,
                        input logic [1:0] burst, input bit toggle);
    int n = 0;
    expectRead(addr, len, size, burst);
    bus.RREADY = 1'b0;
    sendAr(addr, len, size, burst);
    while (rq.size() > 0 && n < 200) begin
      bus.RREADY = toggle ? (n % 2 == 1) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("r_drain", 32'(rq.size()), 32'd0);
    checkOutput("arready_after_r", 32'(bus.ARREADY), 32'd1);
    checkOutput("rvalid_after_r", 32'(bus.RVALID), 32'd0);
  endtask

  // Monitors sample at the falling edge, where the next rising edge's handshake is already decided.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.BVALID && bus.BREADY) begin
        if (bq.size() == 0) checkOutput("b_unexpected", 32'(bq.size()), 32'd1);
        else checkOutput("bresp", 32'(bus.BRESP), 32'(bq.pop_front()));
      end
      if (bus.RVALID) begin
        if (holdValid) checkOutput("rdata_hold", bus.RDATA, holdData);
        if (bus.RREADY) begin
          if (rq.size() == 0) checkOutput("r_unexpected", 32'(rq.size()), 32'd1);
          else begin
            rbeat_t e;
            e = rq.pop_front();
            checkOutput("rdata", bus.RDATA, e.data);
            checkOutput("rresp", 32'(bus.RRESP), 32'(e.resp));
            checkOutput("rlast", 32'(bus.RLAST), 32'(e.last));
          end
        end
        holdValid = !bus.RREADY;
        holdData  = bus.RDATA;
      end else holdValid = 1'b0;
    end else holdValid = 1'b0;
  end

  task automatic checkIdleOutputs(input string phase);
    checkOutput({phase, "_awready"}, 32'(bus.AWREADY), 32'd1);
    checkOutput({phase, "_arready"}, 32'(bus.ARREADY), 32'd1);
    checkOutput({phase, "_wready"},  32'(bus.WREADY),  32'd0);
    checkOutput({phase, "_bvalid"},  32'(bus.BVALID),  32'd0);
    checkOutput({phase, "_bresp"},   32'(bus.BRESP),   32'd0);
    checkOutput({phase, "_rvalid"},  32'(bus.RVALID),  32'd0);
    checkOutput({phase, "_rlast"},   32'(bus.RLAST),   32'd0);
    checkOutput({phase, "_rdata"},   bus.RDATA,        32'd0);
    checkOutput({phase, "_rresp"},   32'(bus.RRESP),   32'd0);
  endtask

  task automatic applyStimulus();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'b010; bus.AWBURST = 2'b01;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'b010; bus.ARBURST = 2'b01;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.BREADY = 1'b1; bus.RREADY = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleOutputs("in_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("after_reset");

    doWrite(32'h0, 0, 3'b010, 2'b00, 32'hDEADBEEF, 4'hF, -1, 1'b1);
    doRead(32'h0, 0, 3'b010, 2'b00, 1'b0);
    doWrite(32'h4, 5, 3'b010, 2'b01, 32'h11, 4'hF, -1, 1'b0);
    doRead(32'h4, 5, 3'b010, 2'b01, 1'b0);
    doWrite(32'd48, 7, 3'b010, 2'b10, 32'hA0, 4'hF, -1, 1'b0);
    doRead(32'd48, 7, 3'b010, 2'b10, 1'b0);
    doRead(32'h4, 3, 3'b010, 2'b01, 1'b1);

    doWrite(32'h10, 0, 3'b010, 2'b01, 32'hFFFFFFFF, 4'b0101, -1, 1'b0);
    doRead(32'h10, 0, 3'b010, 2'b01, 1'b0);

    doWrite(32'h4, 0, 3'b001, 2'b01, 32'hBAD0BAD0, 4'hF, -1, 1'b0);
    doRead(32'h4, 0, 3'b010, 2'b01, 1'b0);
    doWrite(32'h100, 0, 3'b010, 2'b01, 32'h77, 4'hF, -1, 1'b0);
    doRead(32'h100, 0, 3'b010, 2'b01, 1'b0);
    doWrite(32'h0, 2, 3'b010, 2'b10, 32'h99, 4'hF, -1, 1'b0);
    doRead(32'h0, 0, 3'b010, 2'b00, 1'b0);
    doWrite(32'h60, 3, 3'b010, 2'b01, 32'hE0, 4'hF, 1, 1'b0);

    // Read and write of word 2 on the same edge: the read must see the pre-write value.
    expectRead(32'h8, 0, 3'b010, 2'b00);
    expectWrite(32'h8, 0, 3'b010, 2'b01, 32'h55AA55AA, 4'hF, -1);
    bus.RREADY = 1'b1;
    sendAw(32'h8, 0, 3'b010, 2'b01);
    bus.ARADDR = 32'h8; bus.ARLEN = 8'd0; bus.ARSIZE = 3'b010; bus.ARBURST = 2'b00; bus.ARVALID = 1'b1;
    sendW(32'h55AA55AA, 4'hF, 1'b1);
    bus.ARVALID = 1'b0;
    waitDrain();
    doRead(32'h8, 0, 3'b010, 2'b00, 1'b0);

    // Reset lands while beat 2 of an INCR burst is pending; beats 0-1 must survive.
    sendAw(32'h40, 3, 3'b010, 2'b01);
    sendW(32'hC0, 4'hF, 1'b0);
    sendW(32'hC1, 4'hF, 1'b0);
    bus.WDATA = 32'hC2; bus.WVALID = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkIdleOutputs("mid_burst_reset");
    bus.WVALID = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("awready_after_release", 32'(bus.AWREADY), 32'd1);
    model[16] = 32'hC0;
    model[17] = 32'hC1;
    doRead(32'h40, 1, 3'b010, 2'b01, 1'b0);
  endtask

  initial begin
    applyStimulus();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
